// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised LFSR: mode constants, the per-cycle
// control action, and a table of primitive feedback masks.
package lfsr_pkg;

  localparam bit LFSR_FIBONACCI = 1'b0;
  localparam bit LFSR_GALOIS    = 1'b1;

  // What the register does on the coming clock edge; visible for debug probes.
  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_GUARD,
    ACT_STEP
  } lfsr_action_e;

  // Primitive polynomial masks; bit k-1 set means stage k feeds back.
  function automatic logic [31:0] default_taps(input int width);
    int          t [4];
    logic [31:0] m;
    case (width)
      3:       t = '{3, 2, 0, 0};
      4:       t = '{4, 3, 0, 0};
      5:       t = '{5, 3, 0, 0};
      6:       t = '{6, 5, 0, 0};
      7:       t = '{7, 6, 0, 0};
      8:       t = '{8, 6, 5, 4};
      9:       t = '{9, 5, 0, 0};
      10:      t = '{10, 7, 0, 0};
      11:      t = '{11, 9, 0, 0};
      12:      t = '{12, 6, 4, 1};
      13:      t = '{13, 4, 3, 1};
      14:      t = '{14, 5, 3, 1};
      15:      t = '{15, 14, 0, 0};
      16:      t = '{16, 15, 13, 4};
      17:      t = '{17, 14, 0, 0};
      18:      t = '{18, 11, 0, 0};
      19:      t = '{19, 6, 2, 1};
      20:      t = '{20, 17, 0, 0};
      21:      t = '{21, 19, 0, 0};
      22:      t = '{22, 21, 0, 0};
      23:      t = '{23, 18, 0, 0};
      24:      t = '{24, 23, 22, 17};
      25:      t = '{25, 22, 0, 0};
      26:      t = '{26, 6, 2, 1};
      27:      t = '{27, 5, 2, 1};
      28:      t = '{28, 25, 0, 0};
      29:      t = '{29, 27, 0, 0};
      30:      t = '{30, 6, 4, 1};
      31:      t = '{31, 28, 0, 0};
      32:      t = '{32, 22, 2, 1};
      default: t = '{0, 0, 0, 0};
    endcase
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (t[i] > 0) m = m | (32'd1 << (t[i] - 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state of the shift register in either Fibonacci or
// Galois form, plus an all-zero detect on the current state.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 6,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
  parameter bit               GALOIS = LFSR_FIBONACCI
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next,
  output logic             is_zero
);

  logic fb;
  logic msb;

  always_comb begin
    fb      = ^(state & TAPS);
    msb     = state[WIDTH-1];
    is_zero = (state == '0);
    // Galois: the outgoing stage re-enters at stage 1 and toggles every tapped stage above it.
    if (GALOIS == LFSR_GALOIS) begin
      next = {state[WIDTH-2:0], msb} ^ ({TAPS[WIDTH-2:0], 1'b0} & {WIDTH{msb}});
    end else begin
      next = {state[WIDTH-2:0], fb};
    end
  end

endmodule

// File: rtl/lfsr_param.sv
// Parametrised LFSR with seed load, zero-state protection and period
// measurement against the most recently accepted seed.
module lfsr_param
  import lfsr_pkg::*;
#(
  parameter int               WIDTH  = 6,
  parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(6'b110101),
  parameter bit               GALOIS = LFSR_FIBONACCI
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup,
  output logic [WIDTH-1:0] period
);

  // en and load are per-cycle commands with no handshake: each is honoured on
  // the edge it is sampled high, load taking precedence, and nothing stalls.
  logic [WIDTH-1:0] next;
  logic             is_zero;
  logic [WIDTH-1:0] seed_ref;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] load_val;
  logic             load_zero;
  lfsr_action_e     action;

  lfsr_next #(
    .WIDTH  (WIDTH),
    .TAPS   (TAPS),
    .GALOIS (GALOIS)
  ) u_next (
    .state   (state),
    .next    (next),
    .is_zero (is_zero)
  );

  always_comb begin
    action    = ACT_HOLD;
    load_zero = (seed_in == '0);
    load_val  = load_zero ? SEED : seed_in;
    if (load) begin
      action = ACT_LOAD;
    end else if (en) begin
      action = is_zero ? ACT_GUARD : ACT_STEP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= SEED;
      seed_ref <= SEED;
      cnt      <= '0;
      period   <= '0;
      wrap     <= 1'b0;
      lockup   <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      case (action)
        ACT_LOAD: begin
          state    <= load_val;
          seed_ref <= load_val;
          cnt      <= '0;
          lockup   <= load_zero;
        end
        ACT_GUARD: begin
          state    <= SEED;
          seed_ref <= SEED;
          cnt      <= '0;
          lockup   <= 1'b1;
        end
        ACT_STEP: begin
          state <= next;
          // cnt counts steps since the seed was last seen, so cnt+1 is the cycle length.
          if (next == seed_ref) begin
            period <= cnt + WIDTH'(1);
            cnt    <= '0;
            wrap   <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bit_out = state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_param.sv
// Bench for lfsr_param: three instances (6-bit Fibonacci, 6-bit Galois,
// 8-bit Fibonacci) driven in lockstep and scored against a behavioural model.
module tb_lfsr_param;
  import lfsr_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       en;
  logic       load;
  logic [7:0] seed_in;

  logic [5:0] st0, per0, st1, per1;
  logic [7:0] st2, per2;
  logic       bo0, bo1, bo2, wr0, wr1, wr2, lk0, lk1, lk2;

  lfsr_param dut_fib6 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed_in(seed_in[5:0]),
    .state(st0), .bit_out(bo0), .wrap(wr0), .lockup(lk0), .period(per0)
  );

  lfsr_param #(.GALOIS(LFSR_GALOIS)) dut_gal6 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed_in(seed_in[5:0]),
    .state(st1), .bit_out(bo1), .wrap(wr1), .lockup(lk1), .period(per1)
  );

  lfsr_param #(.WIDTH(8), .TAPS(8'b10111000), .SEED(8'hE1)) dut_fib8 (
    .clk(clk), .reset_n(reset_n), .en(en), .load(load), .seed_in(seed_in),
    .state(st2), .bit_out(bo2), .wrap(wr2), .lockup(lk2), .period(per2)
  );

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [56:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_w     [3];
  logic [31:0] m_taps  [3];
  logic [31:0] m_seed  [3];
  bit          m_gal   [3];
  logic [31:0] m_state [3];
  logic [31:0] m_ref   [3];
  logic [31:0] m_cnt   [3];
  logic [31:0] m_period[3];
  bit          m_wrap  [3];
  bit          m_lock  [3];

  function automatic logic [31:0] model_next(input logic [31:0] s, input int w,
                                             input logic [31:0] taps, input bit gal);
    logic [31:0] mask;
    logic [31:0] n;
    logic        o;
    mask = (32'd1 << w) - 32'd1;
    if (!gal) begin
      n = ((s << 1) | {31'd0, ^(s & taps)}) & mask;
    end else begin
      o = |(s & (32'd1 << (w - 1)));
      n = ((s << 1) | {31'd0, o}) & mask;
      if (o) n = n ^ ((taps << 1) & mask);
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i] = m_seed[i]; m_ref[i] = m_seed[i];
      m_cnt[i] = 0; m_period[i] = 0; m_wrap[i] = 0; m_lock[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic e, input logic l, input logic [7:0] sd);
    logic [31:0] mask;
    logic [31:0] sdm;
    logic [31:0] nx;
    mask = (32'd1 << m_w[i]) - 32'd1;
    sdm  = {24'd0, sd} & mask;
    m_wrap[i] = 0;
    m_lock[i] = 0;
    if (l) begin
      if (sdm == 0) begin
        m_state[i] = m_seed[i]; m_ref[i] = m_seed[i]; m_lock[i] = 1;
      end else begin
        m_state[i] = sdm; m_ref[i] = sdm;
      end
      m_cnt[i] = 0;
    end else if (e) begin
      if (m_state[i] == 0) begin
        m_state[i] = m_seed[i]; m_ref[i] = m_seed[i]; m_cnt[i] = 0; m_lock[i] = 1;
      end else begin
        nx = model_next(m_state[i], m_w[i], m_taps[i], m_gal[i]);
        m_state[i] = nx;
        if (nx == m_ref[i]) begin
          m_period[i] = (m_cnt[i] + 1) & mask; m_cnt[i] = 0; m_wrap[i] = 1;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) & mask;
        end
      end
    end
  endtask

  function automatic logic [18:0] model_obs(input int i);
    logic bo;
    bo = |(m_state[i] & (32'd1 << (m_w[i] - 1)));
    return {bo, m_state[i][7:0], m_wrap[i], m_lock[i], m_period[i][7:0]};
  endfunction

  function automatic logic [18:0] dut_obs(input int i);
    case (i)
      0:       return {bo0, 2'b00, st0, wr0, lk0, 2'b00, per0};
      1:       return {bo1, 2'b00, st1, wr1, lk1, 2'b00, per1};
      default: return {bo2, st2, wr2, lk2, per2};
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic e, input logic l, input logic [7:0] sd);
    logic [56:0] exp_all;
    logic [56:0] obs_all;
    @(negedge clk);
    en = e; load = l; seed_in = sd;
    for (int i = 0; i < 3; i++) model_step(i, e, l, sd);
    exp_q.push_back({model_obs(2), model_obs(1), model_obs(0)});
    @(posedge clk);
    #1;
    obs_all = {dut_obs(2), dut_obs(1), dut_obs(0)};
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      exp_all = exp_q.pop_front();
      check("fib6", 32'(obs_all[18:0]),  32'(exp_all[18:0]));
      check("gal6", 32'(obs_all[37:19]), 32'(exp_all[37:19]));
      check("fib8", 32'(obs_all[56:38]), 32'(exp_all[56:38]));
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [5:0] fib_seq [4];
  bit         fib_bo  [4];
  bit         seen    [64];
  int         n;

  initial begin
    m_w    = '{6, 6, 8};
    m_taps = '{32'h30, 32'h30, 32'hB8};
    m_seed = '{32'h35, 32'h35, 32'hE1};
    m_gal  = '{1'b0, 1'b1, 1'b0};
    fib_seq = '{6'b110101, 6'b101010, 6'b010101, 6'b101011};
    fib_bo  = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;

    reset_n = 1'b0; en = 1'b0; load = 1'b0; seed_in = 8'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(st0), 32'h35);
    check("reset_bit_out", 32'(bo0), 32'(fib_bo[0]));
    for (int i = 0; i < 3; i++) check("reset_all", 32'(dut_obs(i)), 32'(model_obs(i)));
    @(negedge clk);
    reset_n = 1'b1;

    // Free run from SEED: known prefix, no zero/repeat, wrap at step 63.
    seen[6'b110101] = 1'b1;
    for (int k = 1; k <= 63; k++) begin
      drive_cycle(1'b1, 1'b0, 8'd0);
      if (k <= 3) begin
        check("fib_prefix_state", 32'(st0), 32'(fib_seq[k]));
        check("fib_prefix_bit_out", 32'(bo0), 32'(fib_bo[k]));
      end
      if (k == 1) check("gal_first_step", 32'(st1), 32'h0B);
      if (k < 63) begin
        check("fib_fresh_state", {30'd0, seen[st0], st0 == 6'd0}, 32'd0);
        seen[st0] = 1'b1;
        check("fib_no_early_wrap", 32'(wr0), 32'd0);
      end
    end
    check("fib_wrap", 32'(wr0), 32'd1);
    check("fib_wrap_state", 32'(st0), 32'h35);
    check("fib_period", 32'(per0), 32'd63);
    check("gal_wrap", 32'(wr1), 32'd1);
    check("gal_period", 32'(per1), 32'd63);

    // Zero seed is rejected and replaced by SEED.
    drive_cycle(1'b0, 1'b1, 8'd0);
    check("zero_load_state", 32'(st0), 32'h35);
    check("zero_load_lockup", 32'(lk0), 32'd1);
    drive_cycle(1'b1, 1'b0, 8'd0);
    check("zero_load_lockup_clear", 32'(lk0), 32'd0);
    check("zero_load_step1", 32'(st0), 32'(fib_seq[1]));
    drive_cycle(1'b1, 1'b0, 8'd0);
    check("zero_load_step2", 32'(st0), 32'(fib_seq[2]));

    // Load wins over en; period then measured from the new seed.
    drive_cycle(1'b1, 1'b1, 8'd1);
    check("load_over_en", 32'(st0), 32'd1);
    n = 0;
    while (n < 100) begin
      drive_cycle(1'b1, 1'b0, 8'd0);
      n++;
      if (wr0 === 1'b1) break;
    end
    check("seed1_wrap_steps", 32'(n), 32'd63);
    check("seed1_period", 32'(per0), 32'd63);

    // Asynchronous reset mid-run, then hold.
    for (int k = 0; k < 20; k++) drive_cycle(1'b1, 1'b0, 8'd0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_state", 32'(st0), 32'h35);
    check("async_reset_period", 32'(per0), 32'd0);
    for (int i = 0; i < 3; i++) check("async_reset_all", 32'(dut_obs(i)), 32'(model_obs(i)));
    @(negedge clk);
    en = 1'b0; load = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, 1'b0, 8'd0);
      check("hold_state", 32'(st0), 32'h35);
      check("hold_wrap", 32'(wr0), 32'd0);
    end

    // 8-bit instance: full period from reset.
    n = 0;
    while (n < 300) begin
      drive_cycle(1'b1, 1'b0, 8'd0);
      n++;
      if (wr2 === 1'b1) break;
    end
    check("w8_wrap_steps", 32'(n), 32'd255);
    check("w8_period", 32'(per2), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lfsr_param.md
# lfsr_param

Parametrised linear-feedback shift register: the next generation of our fixed 6-bit LFSR. It adds generic width and tap mask, Fibonacci or Galois mode, step enable, runtime seed load, all-zero lock-up protection, and period measurement. It sits beside pattern generators and BIST/scrambler logic as a pseudo-random source whose sequence can be restarted on demand.

## Interface
- WIDTH, 6, number of stages (≥3); stage k is `state[k-1]`.
- TAPS, 6'b110000, feedback mask; bit k-1 set means stage k is tapped. Default is P(x)=x^6+x^5+1. TAPS[WIDTH-1] must be 1.
- SEED, 6'b110101, reset/fallback state; must be non-zero.
- GALOIS, 0, 0 = Fibonacci (external XOR), 1 = Galois (internal XOR).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  advance one step this cycle.
- load  in  1  load `seed_in` this cycle (priority over `en`).
- seed_in  in  WIDTH  runtime seed.
- state  out  WIDTH  current register contents.
- bit_out  out  1  serial output, always equal to `state[WIDTH-1]`.
- wrap  out  1  one-cycle pulse: state has returned to the active seed.
- lockup  out  1  one-cycle pulse: zero seed rejected.
- period  out  WIDTH  step count of the last completed cycle.

## Operation
- Fibonacci step:
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}.
- Galois step:
  - o = state[WIDTH-1].
  - next[0] = o.
  - next[i] = state[i-1] ^ (o & TAPS[i-1]) for i = 1..WIDTH-1.
- Primitive TAPS gives period 2^WIDTH−1 in both modes. Sequence order differs between modes.
- Load with non-zero `seed_in`:
  - state and seed_ref both take `seed_in`.
  - cnt clears to 0.
  - period is unchanged.
- Load with zero `seed_in`:
  - state and seed_ref take SEED.
  - cnt clears to 0.
  - lockup pulses for one cycle.
- Zero guard: if state is ever all-zero with `en` asserted, the step loads SEED instead, and lockup pulses.
- Step with `en` and no `load`:
  - state <= next.
  - If next == seed_ref: period <= cnt+1, cnt <= 0, wrap pulses.
  - Otherwise cnt <= cnt+1.
- cnt is WIDTH bits wide. The maximum value 2^WIDTH−1 fits, so no overflow is possible.
- Hold when `en` = 0 and `load` = 0: all registers keep their values; wrap and lockup are 0.
- Simultaneous `load` and `en`: load wins; no step occurs.

## Timing
- Reset values: state = SEED, seed_ref = SEED, cnt = 0, period = 0, wrap = 0, lockup = 0. `bit_out` = SEED[WIDTH-1].
- Reset is asynchronous. Assertion mid-sequence returns all outputs to reset values immediately, regardless of `en` or `load`.
- All outputs are registered or derived directly from registers.
- Latency: the effect of `load` or `en` is visible on `state` one clock later.
- `wrap` and `lockup` go high in the same cycle that the corresponding new state is visible, for exactly one cycle.
- `period` updates in the same cycle as `wrap`.
- Back-to-back loads are accepted every cycle.

## Structure
- Package `lfsr_pkg`:
  - mode constants LFSR_FIBONACCI = 0 and LFSR_GALOIS = 1;
  - function `default_taps(width)` returning a primitive mask for widths 3–32.
- Sub-module `lfsr_next`: purely combinational next-state logic (WIDTH, TAPS, GALOIS → next, is_zero).
- The top level holds the state, seed_ref, cnt and period registers plus the load/step control.

## Test plan
- Reset, then default parameters with `en` = 1 in Fibonacci mode:
  - state sequence 110101 → 101010 → 010101 → 101011.
  - `bit_out` 1, 1, 0, 1.
- Free run for 63 steps from SEED, Fibonacci:
  - `wrap` pulses on step 63 with state = 110101 and `period` = 63.
  - No 000000 state and no repeated state before the wrap.
- GALOIS = 1, one step from 110101 → 001011. Run to wrap → `period` = 63.
- `load` = 1 with `seed_in` = 000000:
  - next cycle state = 110101, `lockup` = 1 for one cycle.
  - following steps match the default sequence.
- `load` with `seed_in` = 000001, asserted together with `en`:
  - state = 000001 with no step taken.
  - `wrap` fires after 63 further steps with `period` = 63.
- `reset_n` asserted low mid-run at step 20:
  - state = 110101 and `period` = 0 immediately.
  - `en` = 0 for 5 cycles → state holds, `wrap` = 0.
- WIDTH = 8, TAPS = 8'b10111000 → `period` = 255 after free run.
